// File: rtl/if_fetch_queue.sv
// if_fetch_queue -- instruction-fetch initiator with a small decode FIFO.
//
// Drives the instruction ROM (chip enable + byte address), takes the
// same-cycle combinational ROM word and buffers each {pc, inst} pair in a
// DEPTH-entry FIFO that feeds decode over a valid/ready handshake. A branch
// redirect flushes the FIFO and restarts fetch at the (word-aligned) target.
//
// Optional feature macro: IF_BYPASS_EN
//   When defined, a word fetched while the FIFO is empty and decode is ready
//   is presented combinationally (0-cycle latency) without entering the FIFO.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous reset, active-low
//   rom_ce           ROM read enable
//   rom_addr         ROM byte address (always the current fetch PC)
//   rom_inst         ROM data, same cycle as rom_ce/rom_addr
//   branch_flag_i    redirect request (highest priority after reset)
//   branch_target_i  redirect address, bits [1:0] ignored
//   id_valid_o       head entry valid
//   id_ready_i       decode accepts the head entry
//   id_pc_o          head entry PC
//   id_inst_o        head entry instruction
//   fifo_count_o     FIFO occupancy
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     rom_ce,
  output logic [31:0]              rom_addr,
  input  logic [31:0]              rom_inst,
  input  logic                     branch_flag_i,
  input  logic [31:0]              branch_target_i,
  output logic                     id_valid_o,
  input  logic                     id_ready_i,
  output logic [31:0]              id_pc_o,
  output logic [31:0]              id_inst_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [31:0]   pc;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [63:0]   last_head;

  logic          fifo_valid;
  logic          fifo_pop;
  logic          fetch;
  logic          bypass;
  logic          push;
  logic [63:0]   head;
  logic [31:0]   target;

  assign target     = branch_target_i & ~32'h0000_0003;
  assign fifo_valid = (count != '0);
  assign fifo_pop   = fifo_valid & id_ready_i;
  // A pop frees a slot in the same cycle, so a full FIFO still fetches.
  assign fetch      = rst & ~branch_flag_i & ((count != CNT_FULL) | fifo_pop);
  assign head       = mem[rd_ptr];

`ifdef IF_BYPASS_EN
  assign bypass = ~fifo_valid & fetch & id_ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign push         = fetch & ~bypass;
  assign rom_ce       = fetch;
  assign rom_addr     = pc;
  assign fifo_count_o = count;

  // Empty FIFO shows the last head that was presented (0 after reset).
  always_comb begin
    id_valid_o = fifo_valid | bypass;
    {id_pc_o, id_inst_o} = last_head;
    if (bypass) begin
      {id_pc_o, id_inst_o} = {pc, rom_inst};
    end else if (fifo_valid) begin
      {id_pc_o, id_inst_o} = head;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {pc, rom_inst};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
    end else begin
      if (bypass) begin
        last_head <= {pc, rom_inst};
      end else if (fifo_valid) begin
        last_head <= head;
      end

      if (branch_flag_i) begin
        // Flush: any pop this cycle is accepted by decode but its entry
        // disappears with the rest of the FIFO.
        pc     <= target;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (fetch)    pc     <= pc + 32'd4;
        if (push)     wr_ptr <= wr_ptr + PTR_ONE;
        if (fifo_pop) rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, fifo_pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [2:0]  fifo_count_o;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce          (rom_ce),
    .rom_addr        (rom_addr),
    .rom_inst        (rom_inst),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .id_valid_o      (id_valid_o),
    .id_ready_i      (id_ready_i),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .fifo_count_o    (fifo_count_o)
  );

  // ROM: word k holds 32'h1000_0000 + k.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign rom_inst = rom_word(rom_addr);

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of {pc, inst} entries plus the fetch PC.
  logic [63:0] m_q[$];
  logic [31:0] m_pc = RESET_PC;

  function automatic bit m_fetch();
    return rst && !branch_flag_i &&
           (m_q.size() < DEPTH || (m_q.size() != 0 && id_ready_i));
  endfunction

  function automatic bit m_bypass();
`ifdef IF_BYPASS_EN
    return m_q.size() == 0 && m_fetch() && id_ready_i;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    bit f, b, p;
    f = m_fetch();
    b = m_bypass();
    p = (m_q.size() != 0) && id_ready_i;
    if (!rst) begin
      m_q.delete();
      m_pc = RESET_PC;
    end else if (branch_flag_i) begin
      m_q.delete();
      m_pc = {branch_target_i[31:2], 2'b00};
    end else begin
      if (p) void'(m_q.pop_front());
      if (f) begin
        if (!b) m_q.push_back({m_pc, rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      bit          vld;
      logic [63:0] hd;
      vld = (m_q.size() != 0) || m_bypass();
      chk("rom_ce", {63'd0, rom_ce}, {63'd0, m_fetch()});
      chk("rom_addr", {32'd0, rom_addr}, {32'd0, m_pc});
      chk("id_valid", {63'd0, id_valid_o}, {63'd0, vld});
      chk("fifo_count", {61'd0, fifo_count_o}, 64'(m_q.size()));
      if (vld) begin
        hd = m_bypass() ? {m_pc, rom_word(m_pc)} : m_q[0];
        chk("id_pc", {32'd0, id_pc_o}, {32'd0, hd[63:32]});
        chk("id_inst", {32'd0, id_inst_o}, {32'd0, hd[31:0]});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0; id_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b1;
    #3;
    chk("rst_ce",    {63'd0, rom_ce}, 64'd0);
    chk("rst_addr",  {32'd0, rom_addr}, {32'd0, RESET_PC});
    chk("rst_valid", {63'd0, id_valid_o}, 64'd0);
    chk("rst_pc",    {32'd0, id_pc_o}, 64'd0);
    chk("rst_inst",  {32'd0, id_inst_o}, 64'd0);
    chk("rst_count", {61'd0, fifo_count_o}, 64'd0);

    // Release and free-run.
    cyc(); rst = 1'b1; id_ready_i = 1'b1; #3;
    chk("rel_ce",   {63'd0, rom_ce}, 64'd1);
    chk("rel_addr", {32'd0, rom_addr}, 64'd0);
`ifndef IF_BYPASS_EN
    chk("rel_valid0", {63'd0, id_valid_o}, 64'd0);
    cyc(); #3;
    chk("rel_valid1", {63'd0, id_valid_o}, 64'd1);
    chk("rel_pc1",    {32'd0, id_pc_o}, 64'd0);
    chk("rel_inst1",  {32'd0, id_inst_o}, 64'h1000_0000);
`else
    chk("byp_valid", {63'd0, id_valid_o}, 64'd1);
    chk("byp_inst",  {32'd0, id_inst_o}, 64'h1000_0000);
    chk("byp_count", {61'd0, fifo_count_o}, 64'd0);
`endif
    repeat (6) cyc();

    // Backpressure from a fresh start.
    rst = 1'b0; id_ready_i = 1'b0;
    cyc(); rst = 1'b1;
    repeat (10) cyc();
    #3;
    chk("bp_count", {61'd0, fifo_count_o}, 64'd4);
    chk("bp_ce",    {63'd0, rom_ce}, 64'd0);
    chk("bp_addr",  {32'd0, rom_addr}, 64'h10);
    chk("bp_head",  {32'd0, id_pc_o}, 64'h0);
    cyc(); id_ready_i = 1'b1; #3;
    chk("drain_ce",   {63'd0, rom_ce}, 64'd1);
    chk("drain_addr", {32'd0, rom_addr}, 64'h10);
    chk("drain_pc0",  {32'd0, id_pc_o}, 64'h0);
    cyc(); #3;
    chk("drain_pc1",   {32'd0, id_pc_o}, 64'h4);
    chk("drain_inst1", {32'd0, id_inst_o}, 64'h1000_0001);
    cyc(); #3;
    chk("drain_pc2", {32'd0, id_pc_o}, 64'h8);
    chk("full_cnt",  {61'd0, fifo_count_o}, 64'd4);

    // Branch with a full FIFO (pop also requested that cycle).
    cyc(); branch_flag_i = 1'b1; branch_target_i = 32'h0000_0043; #3;
    chk("br_ce", {63'd0, rom_ce}, 64'd0);
    cyc(); branch_flag_i = 1'b0; id_ready_i = 1'b0; #3;
    chk("br_count", {61'd0, fifo_count_o}, 64'd0);
    chk("br_valid", {63'd0, id_valid_o}, 64'd0);
    chk("br_addr",  {32'd0, rom_addr}, 64'h40);
    cyc(); #3;
    chk("br_pc", {32'd0, id_pc_o}, 64'h40);

    // Wrap-around of the fetch PC.
    cyc(); branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFF8; id_ready_i = 1'b1;
    cyc(); branch_flag_i = 1'b0; #3;
    chk("wrap_a0", {32'd0, rom_addr}, 64'hFFFF_FFF8);
`ifdef IF_BYPASS_EN
    chk("byp_br_pc", {32'd0, id_pc_o}, 64'hFFFF_FFF8);
`endif
    cyc(); #3;
    chk("wrap_a1", {32'd0, rom_addr}, 64'hFFFF_FFFC);
    cyc(); #3;
    chk("wrap_a2", {32'd0, rom_addr}, 64'h0);
`ifndef IF_BYPASS_EN
    chk("wrap_pc", {32'd0, id_pc_o}, 64'hFFFF_FFFC);
`else
    chk("wrap_pc", {32'd0, id_pc_o}, 64'h0);
`endif

    // Reset mid-stream with three entries queued and a branch pending.
    cyc(); branch_flag_i = 1'b1; branch_target_i = 32'h0000_0100;
    cyc(); branch_flag_i = 1'b0; id_ready_i = 1'b0;
    repeat (3) cyc();
    rst = 1'b0; branch_flag_i = 1'b1; id_ready_i = 1'b1; #3;
    chk("mid_count3", {61'd0, fifo_count_o}, 64'd3);
    chk("mid_ce",     {63'd0, rom_ce}, 64'd0);
    cyc(); branch_flag_i = 1'b0; #3;
    chk("mrst_count", {61'd0, fifo_count_o}, 64'd0);
    chk("mrst_valid", {63'd0, id_valid_o}, 64'd0);
    chk("mrst_ce",    {63'd0, rom_ce}, 64'd0);
    chk("mrst_addr",  {32'd0, rom_addr}, {32'd0, RESET_PC});
    chk("mrst_pc",    {32'd0, id_pc_o}, 64'd0);
    chk("mrst_inst",  {32'd0, id_inst_o}, 64'd0);
    cyc(); rst = 1'b1; #3;
    chk("restart_ce",   {63'd0, rom_ce}, 64'd1);
    chk("restart_addr", {32'd0, rom_addr}, {32'd0, RESET_PC});
    repeat (4) cyc();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction-fetch initiator that drives the instruction ROM's chip-enable and address and takes its same-cycle combinational instruction word. It keeps the fetch PC, buffers each fetched {pc, inst} pair in a small FIFO, and hands the pairs to decode over a valid/ready handshake. A branch redirect flushes the FIFO and restarts fetch at the target. It sits between the instruction ROM and the IF/ID stage.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of two, minimum 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-low (0 = reset), sampled on the `clk` rising edge.
- `rom_ce`  out  1  ROM chip enable; 1 = read.
- `rom_addr`  out  32  byte address to the ROM; bits [1:0] are always 0.
- `rom_inst`  in  32  ROM data, valid in the same cycle as `rom_ce`/`rom_addr`.
- `branch_flag_i`  in  1  redirect request from execute/decode.
- `branch_target_i`  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- `id_valid_o`  out  1  head entry valid.
- `id_ready_i`  in  1  decode accepts the head entry this cycle.
- `id_pc_o`  out  32  PC of the head entry.
- `id_inst_o`  out  32  instruction of the head entry.
- `fifo_count_o`  out  log2(DEPTH)+1  current occupancy.

## Operation
- State:
  - `pc` (32 bits).
  - FIFO storage of DEPTH × 64 bits.
  - Read and write pointers of log2(DEPTH) bits each, wrapping naturally.
  - `count`.
- Reset (`rst`==0 at the edge):
  - `pc` ← RESET_PC; pointers ← 0; `count` ← 0.
  - While `rst` is 0, `rom_ce` is forced to 0 combinationally.
- `pop` = `id_valid_o` & `id_ready_i`.
- `fetch` = `rst` & !`branch_flag_i` & (`count` < DEPTH | `pop`).
  - `rom_ce` = `fetch`; `rom_addr` = `pc`.
  - When `rom_ce` is 0, `rom_addr` holds `pc`.
- On `fetch`:
  - Write {`pc`, `rom_inst`} at the write pointer.
  - `pc` ← `pc` + 4. The add wraps modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0.
- On `pop`: read pointer +1.
- `count` update:
  - fetch and pop together: unchanged.
  - fetch only: +1.
  - pop only: −1.
- Full FIFO with `id_ready_i` = 1: the pop and the fetch happen in the same cycle, so there is no bubble.
- `branch_flag_i` = 1 has priority over everything else:
  - Pointers ← 0 and `count` ← 0.
  - `pc` ← {`branch_target_i`[31:2], 2'b00}.
  - No ROM read that cycle.
  - Any pop that cycle is still honoured by decode, but its entry is discarded with the flush.
- `id_valid_o` = (`count` != 0). `id_pc_o` and `id_inst_o` come from the head entry and are registered storage, not taken from the ROM path.
- When the FIFO is empty, `id_pc_o` and `id_inst_o` hold the last head value; 0 after reset.

## Timing
- Reset values: `rom_ce` 0; `rom_addr` RESET_PC; `id_valid_o` 0; `id_pc_o` 0; `id_inst_o` 0; `fifo_count_o` 0.
- The first ROM read (at RESET_PC) happens in the first cycle with `rst` = 1.
- Fetch-to-decode latency is 1 cycle: a word fetched in cycle N is presented in cycle N+1.
- Branch:
  - Asserted in cycle N: `id_valid_o` = 0 in N+1.
  - Fetch of the target happens in N+1; the target is presented in N+2.
  - Branch penalty is 2 cycles.
- Steady state with `id_ready_i` held at 1: one instruction per cycle, `count` stays at 1.
- `id_ready_i` = 0 from empty: the FIFO fills in DEPTH cycles, then `rom_ce` = 0 and `pc` freezes.
- Reset asserted mid-stream wins over branch, fetch and pop. All entries are lost.

## Configuration
- `IF_BYPASS_EN` undefined:
  - Behaviour exactly as above; latency 1.
- `IF_BYPASS_EN` defined:
  - Applies when `count` == 0, `fetch` = 1 and `id_ready_i` = 1.
  - `id_valid_o` = 1, `id_pc_o` = `pc`, `id_inst_o` = `rom_inst` combinationally.
  - The entry is not written to the FIFO; `count` stays 0 and `pc` still advances.
  - This gives 0-cycle latency and cuts the branch penalty to 1 cycle.
  - In all other cases the FIFO path is used unchanged.
  - `branch_flag_i` = 1 suppresses the bypass.

## Test plan
- Reset then free-run:
  - ROM word k = 32'h1000_0000 + k; `rst` released; `id_ready_i` = 1.
  - Expect pc 0, 4, 8, … paired with 32'h1000_0000, 32'h1000_0001, … on consecutive cycles.
  - Expect the first `id_valid_o` on the 2nd cycle after release.
- Backpressure:
  - `id_ready_i` = 0 for 10 cycles.
  - Expect `fifo_count_o` to rise to 4, then `rom_ce` = 0 and `rom_addr` stuck at 32'h10.
  - Release: entries 0x0–0xC drain in order, with the fetch of 0x10 in the same cycle as the first pop.
- Branch with full FIFO:
  - `branch_flag_i` = 1, `branch_target_i` = 32'h0000_0043.
  - Next cycle: `fifo_count_o` 0, `id_valid_o` 0, `rom_addr` 32'h40.
  - Following cycle: `id_pc_o` = 32'h40.
- Wrap-around:
  - Branch to 32'hFFFF_FFF8.
  - Expect fetches at FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset mid-stream:
  - Assert `rst` = 0 while `fifo_count_o` = 3 and `branch_flag_i` = 1.
  - Next cycle: all outputs at reset values, `rom_ce` 0.
  - After release, fetch restarts at RESET_PC.
- `IF_BYPASS_EN`:
  - FIFO empty, `id_ready_i` = 1.
  - Same-cycle `id_inst_o` == `rom_inst`; `fifo_count_o` stays 0.
  - Branch penalty measured as 1 cycle.
